// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared flag indices, opcode tags and result entry type
package alu_pkg;

  localparam int ALU_WIDTH = 4;
  localparam int ALU_OPW   = 3;
  localparam int FLAGS_W   = 4;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  localparam logic [ALU_OPW-1:0] SHL = 3'd0;
  localparam logic [ALU_OPW-1:0] SHR = 3'd1;
  localparam logic [ALU_OPW-1:0] ADD = 3'd2;
  localparam logic [ALU_OPW-1:0] SUB = 3'd3;
  localparam logic [ALU_OPW-1:0] MUL = 3'd4;
  localparam logic [ALU_OPW-1:0] CMP = 3'd5;

  typedef struct packed {
    logic [ALU_OPW-1:0]   op;
    logic [ALU_WIDTH-1:0] low;
    logic [ALU_WIDTH-1:0] high;
    logic [FLAGS_W-1:0]   flags;
  } alu_entry_t;

endpackage

// File: rtl/alu_flag_gen.sv
// rtl/alu_flag_gen.sv - combinational {V,C,N,Z} status flags for one ALU result
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] in_low,
  input  logic [WIDTH-1:0] in_high,
  input  logic             in_carry,
  output logic [3:0]       flags
);

  always_comb begin
    flags         = '0;
    flags[FLAG_Z] = (in_low == '0) && (in_high == '0);
    flags[FLAG_N] = in_low[WIDTH-1];
    flags[FLAG_C] = in_carry;
    flags[FLAG_V] = |in_high;
  end

endmodule

// File: rtl/alu_result_queue.sv
// rtl/alu_result_queue.sv - FIFO of ALU results with capture-time flags
module alu_result_queue
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 4,
  parameter int OPW   = ALU_OPW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OPW-1:0]         in_op,
  input  logic [WIDTH-1:0]       in_low,
  input  logic [WIDTH-1:0]       in_high,
  input  logic                   in_carry,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OPW-1:0]         out_op,
  output logic [WIDTH-1:0]       out_low,
  output logic [WIDTH-1:0]       out_high,
  output logic [3:0]             out_flags,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  alu_entry_t     mem_q [DEPTH];
  alu_entry_t     wr_entry;
  alu_entry_t     head;
  logic [PW-1:0]  wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]  count_q, count_d;
  logic [3:0]     in_flags;
  logic           push, pop;

  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .in_low   (in_low),
    .in_high  (in_high),
    .in_carry (in_carry),
    .flags    (in_flags)
  );

  // Handshake status comes only from registered count, never from in_valid/out_ready.
  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign wr_entry = '{op: in_op, low: in_low, high: in_high, flags: in_flags};
  assign head     = mem_q[rp_q];

  assign out_op    = head.op;
  assign out_low   = head.low;
  assign out_high  = head.high;
  assign out_flags = head.flags;
  assign count     = count_q;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (push) wp_d = wp_q + 1'b1;
      if (pop)  rp_d = rp_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      // A flushed push is dropped; stale entries are left in place.
      if (push && !flush) mem_q[wp_q] <= wr_entry;
    end
  end

endmodule

// File: tb/tb_alu_result_queue.sv
// tb/tb_alu_result_queue.sv - directed self-checking bench for alu_result_queue
module tb_alu_result_queue;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, flush, in_valid, in_ready, in_carry;
  logic       out_valid, out_ready;
  logic [2:0] in_op, out_op;
  logic [3:0] in_low, in_high, out_low, out_high, out_flags;
  logic [2:0] count;

  int n_pass  = 0;
  int n_total = 0;

  alu_result_queue #(.WIDTH(4), .DEPTH(4), .OPW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_low    (in_low),
    .in_high   (in_high),
    .in_carry  (in_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_op    (out_op),
    .out_low   (out_low),
    .out_high  (out_high),
    .out_flags (out_flags),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [3:0] lo,
                       input logic [3:0] hi, input logic c);
    in_valid = v;
    in_op    = op;
    in_low   = lo;
    in_high  = hi;
    in_carry = c;
  endtask

  initial begin
    logic [3:0] v;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, SUB, 4'h5, 4'h6, 1'b1);
    tick();
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_out_op", out_op, 0);
    chk("rst_out_low", out_low, 0);
    chk("rst_out_high", out_high, 0);
    chk("rst_out_flags", out_flags, 0);
    rst_n = 1'b1;
    drive(1'b0, SHL, 4'h0, 4'h0, 1'b0);
    tick();
    chk("rst_nothing_enq", count, 0);

    drive(1'b1, ADD, 4'hA, 4'h0, 1'b0);
    tick();
    drive(1'b0, SHL, 4'h0, 4'h0, 1'b0);
    chk("single_valid", out_valid, 1);
    chk("single_low", out_low, 4'hA);
    chk("single_op", out_op, 2);
    chk("single_flags", out_flags, 4'b0010);
    out_ready = 1'b1;
    tick();
    chk("single_pop_count", count, 0);
    chk("single_pop_valid", out_valid, 0);
    out_ready = 1'b0;

    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, SHR, 4'(i), 4'h0, 1'b0);
      tick();
    end
    chk("fill_count", count, 4);
    chk("fill_in_ready", in_ready, 0);
    drive(1'b1, SHR, 4'h5, 4'h0, 1'b0);
    tick();
    chk("full_hold_count", count, 4);
    chk("full_hold_head", out_low, 1);
    drive(1'b0, SHL, 4'h0, 4'h0, 1'b0);
    out_ready = 1'b1;
    tick();
    chk("drain_in_ready", in_ready, 1);
    chk("drain_count3", count, 3);
    chk("drain_low2", out_low, 2);
    tick();
    chk("drain_low3", out_low, 3);
    tick();
    chk("drain_low4", out_low, 4);
    tick();
    chk("drain_empty", out_valid, 0);
    out_ready = 1'b0;

    drive(1'b1, SUB, 4'h6, 4'h0, 1'b1);
    tick();
    drive(1'b1, SUB, 4'h7, 4'h0, 1'b1);
    tick();
    chk("pp_pre_count", count, 2);
    chk("pp_pre_head", out_low, 6);
    drive(1'b1, SUB, 4'h8, 4'h0, 1'b1);
    out_ready = 1'b1;
    tick();
    drive(1'b0, SHL, 4'h0, 4'h0, 1'b0);
    chk("pp_count", count, 2);
    chk("pp_head7", out_low, 7);
    tick();
    chk("pp_head8", out_low, 8);
    tick();
    chk("pp_empty", count, 0);
    out_ready = 1'b0;

    drive(1'b1, MUL, 4'h0, 4'h3, 1'b1);
    tick();
    drive(1'b1, CMP, 4'h0, 4'h0, 1'b0);
    chk("mul_flags", out_flags, 4'b1100);
    chk("mul_high", out_high, 3);
    chk("mul_op", out_op, 4);
    tick();
    drive(1'b0, SHL, 4'h0, 4'h0, 1'b0);
    out_ready = 1'b1;
    tick();
    chk("zero_flags", out_flags, 4'b0001);
    chk("zero_op", out_op, 5);
    tick();
    chk("flags_empty", count, 0);
    out_ready = 1'b0;

    for (int i = 9; i <= 11; i++) begin
      drive(1'b1, ADD, 4'(i), 4'h0, 1'b0);
      tick();
    end
    chk("flush_pre_count", count, 3);
    flush = 1'b1; out_ready = 1'b1;
    drive(1'b1, ADD, 4'hC, 4'h0, 1'b0);
    tick();
    flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, SHL, 4'h0, 4'h0, 1'b0);
    chk("flush_count", count, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    tick();
    chk("flush_stays_empty", count, 0);
    drive(1'b1, ADD, 4'hD, 4'h0, 1'b0);
    tick();
    drive(1'b0, SHL, 4'h0, 4'h0, 1'b0);
    chk("post_flush_head", out_low, 4'hD);
    chk("post_flush_count", count, 1);
    out_ready = 1'b1;
    tick();
    chk("post_flush_empty", count, 0);

    for (int i = 0; i < 10; i++) begin
      v = 4'((i * 3 + 1) % 16);
      drive(1'b1, ADD, v, 4'h0, 1'b0);
      tick();
      chk($sformatf("wrap_low%0d", i), out_low, v);
      chk($sformatf("wrap_count%0d", i), count, 1);
    end
    drive(1'b0, SHL, 4'h0, 4'h0, 1'b0);
    tick();
    chk("wrap_empty", count, 0);
    out_ready = 1'b0;

    drive(1'b1, MUL, 4'h9, 4'h2, 1'b0);
    tick();
    drive(1'b0, SHL, 4'h0, 4'h0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_count", count, 0);
    chk("midrst_low", out_low, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_result_queue.md
# alu_result_queue

Registered result buffer directly downstream of the arithmetic units: shift, add/subtract, multiply and compare. It accepts one result per cycle over a valid/ready handshake, computes status flags at capture, and holds up to DEPTH entries in FIFO order. It then presents them to the writeback/consumer stage over a second valid/ready handshake. This decouples the combinational ALU datapath from a stalling consumer.

## Interface
- WIDTH, 4: operand/result width; must be ≥2.
- DEPTH, 4: entries; power of two, ≥2.
- OPW, 3: width of the opcode tag carried with each result.

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  synchronous queue clear.
- in_valid  in  1  producer has a result.
- in_ready  out  1  queue can accept.
- in_op  in  OPW  opcode tag.
- in_low  in  WIDTH  result low word (out / out_low).
- in_high  in  WIDTH  high word (multiply out_high or shift overflow; 0 otherwise).
- in_carry  in  1  final carry/borrow from adder/subtractor.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head.
- out_op  out  OPW  head opcode tag.
- out_low  out  WIDTH  head low word.
- out_high  out  WIDTH  head high word.
- out_flags  out  4  head flags {V,C,N,Z} (bit3..bit0).
- count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- push = in_valid & in_ready; pop = out_valid & out_ready.
- Flags are computed from the in_* values in the push cycle and stored with the entry:
  - Z = (in_low==0) & (in_high==0).
  - N = in_low[WIDTH-1].
  - C = in_carry.
  - V = |in_high.
- Storage is a DEPTH-entry register array with write pointer wp, read pointer rp and count.
  - Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
- out_* are driven from the entry at rp.
- in_ready = (count < DEPTH). There is no enqueue-when-full even if a pop happens in the same cycle.
- out_valid = (count != 0). No bypass: an empty queue never presents the in_* values in the same cycle.
- Simultaneous push and pop (0<count<DEPTH): both pointers advance; count unchanged.
- push when full: impossible because in_ready=0. in_valid held high is not accepted and is not an error.
- pop when empty: impossible because out_valid=0. out_ready is ignored.
- Consumer must not rely on out_* when out_valid=0.
- flush=1: next cycle wp=rp=0 and count=0. Flush overrides any same-cycle push and pop; the pushed data is discarded. Entry contents are not cleared.
- rst_n=0 (dominates flush): wp=rp=count=0 and all entries cleared to 0. Reset in mid-stream drops all contents.

## Timing
- Reset values: in_ready=1, out_valid=0, count=0, out_op=0, out_low=0, out_high=0, out_flags=0.
- Latency: a push at edge N gives out_valid=1 with that data after edge N, i.e. visible in cycle N+1.
- Throughput: one push and one pop per cycle sustained.
- in_ready and out_valid are pure functions of registered count; no combinational path from in_valid or out_ready to either.
- out_* change only at a clock edge (pop, reset, or first push into an empty queue).

## Structure
- Shared package alu_pkg holds:
  - flag bit indices FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3;
  - opcode tag localparams (SHL, SHR, ADD, SUB, MUL, CMP);
  - the entry struct {op, low, high, flags}.
- Sub-module alu_flag_gen: combinational, WIDTH-parameterized, in_low/in_high/in_carry → 4-bit flags. It is reused by later status logic.
- The queue body (pointers, count, array) lives in alu_result_queue itself.

## Test plan
- Reset: hold rst_n=0 two cycles with in_valid=1 → in_ready=1, out_valid=0, count=0, all out_* = 0; nothing enqueued.
- Single push op=2, low=4'hA, high=0, carry=0 → next cycle out_valid=1, out_low=4'hA, out_flags=4'b0010; pop → count=0, out_valid=0.
- Fill with out_ready=0: push low=1,2,3,4 → count=4, in_ready=0. A 5th in_valid is held and ignored. Then out_ready=1 drains 1,2,3,4 in order, and in_ready rises the cycle after the first pop.
- Simultaneous push/pop at count=2 → count stays 2; output order is preserved.
- Multiply result low=4'h0, high=4'h3, carry=1 → out_flags=4'b1100. Result low=0, high=0 → 4'b0001.
- flush=1 together with push and pop at count=3 → count=0 next cycle, out_valid=0, and the flushed push never appears.
- Wrap: 10 back-to-back push/pops with out_ready=1 → all values in order and count never exceeds 1.
